// File: rtl/iccm_load_sequencer_pkg.sv
// Shared types and constants for the ICCM boot-load sequencer.
package iccm_load_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } load_state_e;

  localparam logic [31:0] END_MARKER_DEFAULT = 32'h0000_0FFF;
  localparam int          BYTES_PER_WORD     = 4;
  localparam int          BYTE_CNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/iccm_load_sequencer_if.sv
// ICCM write port: the sequencer is master, the ICCM (or the bench) is slave.
interface iccm_load_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_gnt_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_gnt_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_gnt_i
  );
endinterface

// File: rtl/iccm_load_sequencer_fifo.sv
// Small synchronous word FIFO; a push into a full FIFO succeeds only with a same-cycle pop.
module iccm_load_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rptr[PTR_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      // NOTE: storage is reset because the head drives mem_wdata_o, which must read 0 out of reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[PTR_W-1:0]] <= i_wdata;
        r_wptr                   <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/iccm_load_sequencer.sv
// Boot-load sequencer: UART bytes / SPI words -> FIFO -> sequential ICCM writes until END_MARKER.
// Optional trailing checksum word enabled by ICCM_LOAD_CHECKSUM_EN.
module iccm_load_sequencer
  import iccm_load_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] END_MARKER = END_MARKER_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sel_i,
  input  logic        uart_dv_i,
  input  logic [7:0]  uart_byte_i,
  input  logic        spi_valid_i,
  input  logic [31:0] spi_word_i,
  iccm_load_sequencer_if.master mem,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o,
  output logic        err_o
);
  load_state_e           r_state;
  load_state_e           w_state_n;
  logic                  r_sel;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [23:0]           r_word_lo;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_wrap;
  logic                  r_ovf;
  logic                  r_err;

  logic        w_src_uart;
  logic        w_open;
  logic        w_uart_hit;
  logic        w_spi_hit;
  logic        w_strobe;
  logic        w_last_byte;
  logic        w_push;
  logic [31:0] w_push_data;
  logic        w_pop;
  logic        w_flush;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_head;
  logic        w_head_is_end;
  logic        w_want_write;
  logic        w_req;
  logic        w_gnt;
  logic        w_set_err;
  logic        w_drop;

  // Source is live in IDLE and frozen once the first strobe has started the load.
  assign w_src_uart  = (r_state == IDLE) ? sel_i : r_sel;
  assign w_open      = (r_state != DONE);
  assign w_uart_hit  = w_open && w_src_uart && uart_dv_i;
  assign w_spi_hit   = w_open && !w_src_uart && spi_valid_i;
  assign w_strobe    = w_uart_hit || w_spi_hit;
  assign w_last_byte = (r_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign w_push      = w_spi_hit || (w_uart_hit && w_last_byte);
  assign w_push_data = w_src_uart ? {uart_byte_i, r_word_lo} : spi_word_i;
  assign w_flush     = (r_state == DONE);
  assign w_drop      = w_push && w_full && !w_pop;

  iccm_load_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Address is a flop and data is the FIFO head, which cannot move until the grant pops it.
  assign w_head_is_end   = !w_empty && (w_head == END_MARKER);
  assign w_want_write    = (r_state == LOAD) && !w_empty && !w_head_is_end;
  assign w_req           = w_want_write && !r_wrap;
  assign w_gnt           = w_req && mem.mem_gnt_i;
  assign mem.mem_req_o   = w_req;
  assign mem.mem_addr_o  = r_addr;
  assign mem.mem_wdata_o = w_head;

  assign busy_o = (r_state == LOAD);
  assign done_o = (r_state == DONE);
  assign ovf_o  = r_ovf;
  assign err_o  = r_err;

`ifdef ICCM_LOAD_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    r_sum <= '0;
    else if (w_gnt) r_sum <= r_sum + w_head;
  end
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_n = r_state;
    w_pop     = 1'b0;
    w_set_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_strobe) w_state_n = LOAD;
      end
      LOAD: begin
        if (w_head_is_end) begin
          w_pop = 1'b1;
`ifdef ICCM_LOAD_CHECKSUM_EN
          w_state_n = CHECK;
`else
          w_state_n = DONE;
`endif
        end else if (w_want_write && r_wrap) begin
          w_set_err = 1'b1;
          w_state_n = DONE;
        end else if (w_gnt) begin
          w_pop = 1'b1;
        end
      end
`ifdef ICCM_LOAD_CHECKSUM_EN
      CHECK: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_set_err = (w_head != r_sum);
          w_state_n = DONE;
        end
      end
`endif
      DONE:    w_state_n = DONE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_sel      <= 1'b0;
      r_byte_cnt <= '0;
      r_word_lo  <= '0;
      r_addr     <= '0;
      r_wrap     <= 1'b0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if ((r_state == IDLE) && w_strobe) r_sel <= sel_i;
      // Bytes shift in from the top so the first byte ends up in bits [7:0].
      if (w_uart_hit) begin
        r_word_lo  <= {uart_byte_i, r_word_lo[23:8]};
        r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 1'b1;
      end
      if (w_gnt) begin
        r_addr <= r_addr + 1'b1;
        if (&r_addr) r_wrap <= 1'b1;
      end
      if (w_drop)    r_ovf <= 1'b1;
      if (w_set_err) r_err <= 1'b1;
    end
  end

endmodule

// File: doc/iccm_load_sequencer.md
Name: iccm_load_sequencer

Overview:
- Boot-load controller that sequences ICCM programming from either the UART programmer byte stream or the SPI slave word stream.
- Assembles UART bytes into 32-bit words, buffers words in a small FIFO, and issues them as sequential ICCM writes over a req/gnt write port.
- Detects the end-of-image marker and then asserts done, which the reset manager uses to release the core.
- Sits between the UART receiver / SPI slave and the ICCM write port, on the synchronized boot reset domain.

Parameters:
- ADDR_W, 12, ICCM word-address width.
- FIFO_DEPTH, 2, word buffer depth; power of two, at least 2.
- END_MARKER, 32'h00000FFF, end-of-image word; never written to ICCM.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- sel_i  in  1  source select: 1 = UART, 0 = SPI.
- uart_dv_i  in  1  one-cycle strobe: byte valid.
- uart_byte_i  in  8  UART byte.
- spi_valid_i  in  1  one-cycle strobe: word valid.
- spi_word_i  in  32  SPI word.
- mem_req_o  out  1  ICCM write request.
- mem_addr_o  out  ADDR_W  ICCM word address.
- mem_wdata_o  out  32  ICCM write data.
- mem_gnt_i  in  1  write accepted this cycle.
- busy_o  out  1  load in progress.
- done_o  out  1  image complete; level signal.
- ovf_o  out  1  sticky: word dropped because the FIFO was full.
- err_o  out  1  sticky: address overflow or checksum mismatch.

Behaviour:
- Reset values: all outputs 0, address counter 0, byte counter 0, FIFO empty, state IDLE.
- States:
  - IDLE: first accepted strobe from the selected source → LOAD. sel_i is latched on this transition.
  - LOAD: accepts input and issues writes.
  - DONE: terminal state; exits only through reset.
- Source select:
  - Strobes from the unselected source are ignored.
  - sel_i changes after leaving IDLE are ignored; the latched value governs.
- UART assembly:
  - Bytes are packed little-endian: first byte goes to bits [7:0].
  - On the 4th byte the word is pushed and the byte counter wraps to 0.
- SPI: each spi_valid_i pushes spi_word_i directly.
- Push timing: a push in cycle N makes the word visible at the FIFO head in cycle N+1.
- Write port:
  - mem_req_o = (state==LOAD) && FIFO not empty && head != END_MARKER.
  - mem_addr_o and mem_wdata_o are driven from flops and held stable while mem_req_o is high and mem_gnt_i is low.
  - On req && gnt: pop the FIFO and increment the address.
  - mem_gnt_i is ignored while mem_req_o is low.
- End marker: when the FIFO head equals END_MARKER in LOAD, pop it without writing and go to DONE next cycle. All remaining FIFO content is discarded.
- busy_o is 1 exactly in LOAD. done_o is 1 exactly in DONE.
- FIFO full:
  - A push while full with no pop in the same cycle drops the word and sets ovf_o.
  - A push and pop in the same full cycle both succeed.
- Address overflow: a grant at address 2^ADDR_W-1 sets a wrap flag. Any further write request then sets err_o and goes to DONE, with no write issued.
- DONE: all inputs are ignored; no requests are issued.
- Reset asserted mid-load: all state clears asynchronously; mem_req_o drops immediately. A partially assembled word is lost.

Optional Feature:
- Macro: ICCM_LOAD_CHECKSUM_EN.
- With the macro defined:
  - A 32-bit modular sum is kept over every word written.
  - After END_MARKER the state is CHECK; the next pushed word is compared to the sum and is never written.
  - On mismatch, err_o is set. Either way the next state is DONE.
  - done_o is asserted even on mismatch; the integrator gates core release with !err_o.
- Without the macro: no CHECK state and no adder; END_MARKER goes directly to DONE.

Decomposition:
- Shared package iccm_load_pkg:
  - load_state_e enum (IDLE, LOAD, CHECK, DONE).
  - END_MARKER_DEFAULT constant.
  - BYTES_PER_WORD = 4.
- One sub-module: iccm_load_fifo, a synchronous word FIFO with push/pop/full/empty, async active-low reset, and same-cycle push+pop when full.

Test Plan:
- UART, sel_i=1, gnt tied 1; bytes 78 56 34 12, EF BE AD DE, FF 0F 00 00 → writes 0x12345678@0, 0xDEADBEEF@1; done_o=1, busy_o=0, err_o=0.
- SPI, sel_i=0; words 0xA5A5A5A5, 0x0000_0FFF; gnt held low 5 cycles → req, addr=0 and data stable for 5 cycles; one write; done_o=1; UART strobes during the load are ignored.
- SPI, gnt=0, 3 back-to-back words with FIFO_DEPTH=2 → ovf_o=1; only the first 2 words are written after gnt rises.
- Reset asserted after 2 UART bytes, then reloaded → first written word is built only from post-reset bytes; address restarts at 0.
- ADDR_W=2, 5 SPI data words → addresses 0..3 written, err_o=1, state DONE, no 5th write.
- ICCM_LOAD_CHECKSUM_EN: words 1, 2, END_MARKER, 3 → done_o=1, err_o=0. Repeating with a checksum word of 4 → err_o=1.
